// File: rtl/mdu_pkg.sv
// Package: mdu_pkg
// Shared operation/state encodings and default timing for the E-stage
// multiply/divide unit (mdu_arith, mdu_sequencer).
package mdu_pkg;

  // Operation codes carried on mdu_op. Any other 4-bit value is a NOP.
  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Default latencies; the sequencer exposes them as parameters.
  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;
  localparam int unsigned MDU_CNT_W       = 4;

  function automatic logic is_mul(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Module: mdu_arith
// Combinational multiply/divide datapath. Produces the HI/LO pair the
// sequencer parks in its shadow registers on issue.
// Ports:
//   op    in   operation (mdu_op_e)
//   in1   in   32-bit rs operand (multiplicand / dividend)
//   in2   in   32-bit rt operand (multiplier / divisor)
//   hi_n  out  product high word, or remainder
//   lo_n  out  product low word, or quotient
//   dz    out  divide op with a zero divisor (result must not be committed)
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        dz
);

  logic        signed_mul;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  logic        sa;
  logic        sb;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // A 64x64 product truncated to 64 bits of sign-extended operands is the
  // exact two's-complement signed product, so one multiplier serves both.
  always_comb begin
    signed_mul = (op == MDU_MULT);
    a_ext      = signed_mul ? {{32{in1[31]}}, in1} : {32'd0, in1};
    b_ext      = signed_mul ? {{32{in2[31]}}, in2} : {32'd0, in2};
    prod       = a_ext * b_ext;
  end

  // Signed division runs on magnitudes and re-applies signs: the quotient
  // truncates toward zero and the remainder takes the dividend's sign.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to
  // itself, remainder 0.
  always_comb begin
    sa    = (op == MDU_DIV) & in1[31];
    sb    = (op == MDU_DIV) & in2[31];
    a_mag = sa ? -in1 : in1;
    b_mag = sb ? -in2 : in2;
    dz    = is_div(op) && (in2 == 32'd0);
    // Substitute a divisor of 1 so the divider never sees zero; the dz
    // flag suppresses the commit anyway.
    b_div = (in2 == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (sa ^ sb) ? -q_mag : q_mag;
    rem   = sa ? -r_mag : r_mag;
  end

  always_comb begin
    hi_n = 32'd0;
    lo_n = 32'd0;
    if (is_mul(op)) begin
      hi_n = prod[63:32];
      lo_n = prod[31:0];
    end else if (is_div(op)) begin
      hi_n = rem;
      lo_n = quot;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Module: mdu_sequencer
// Multi-cycle sequencer for the E-stage multiply/divide unit. Accepts one
// mult/div/mthi/mtlo command per issue, holds the result in private shadow
// registers, commits HI/LO after a fixed latency and reports busy to the
// stall controller. A CP0 flush (req) blocks issue so a flushed E-stage
// instruction never touches HI/LO.
// Ports:
//   clk     in   clock, all state on rising edge
//   reset   in   synchronous active-high reset
//   start   in   E-stage holds an MDU-class instruction this cycle
//   mdu_op  in   4-bit operation code (mdu_op_e)
//   in1     in   32-bit rs operand
//   in2     in   32-bit rt operand
//   req     in   CP0 exception/interrupt request, flushes the E-stage issue
//   busy    out  registered: operation in flight
//   hi      out  architectural HI
//   lo      out  architectural LO
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int unsigned CNT_W       = MDU_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_op_e    op;
  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic [31:0] shadow_lo_q, shadow_lo_d;
  logic        shadow_dz_q, shadow_dz_d;
  logic        busy_q;

  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_dz;
  logic        issue;

  assign op = mdu_op_e'(mdu_op);

  mdu_arith u_arith (
    .op   (op),
    .in1  (in1),
    .in2  (in2),
    .hi_n (arith_hi),
    .lo_n (arith_lo),
    .dz   (arith_dz)
  );

  // A flush on the same cycle cancels the issue outright. start during RUN
  // is not expected (the stall controller holds D on busy) and is ignored.
  assign issue = (state_q == MDU_IDLE) && start && !req;

  always_comb begin
    // NOTE: every combinational output takes its hold value first, so no
    // path through the case/if tree leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    shadow_dz_d = shadow_dz_q;

    unique case (state_q)
      MDU_IDLE: begin
        if (issue) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              state_d     = MDU_RUN;
              cnt_d       = CNT_W'(MULT_CYCLES);
              shadow_hi_d = arith_hi;
              shadow_lo_d = arith_lo;
              shadow_dz_d = 1'b0;
            end
            MDU_DIV, MDU_DIVU: begin
              state_d     = MDU_RUN;
              cnt_d       = CNT_W'(DIV_CYCLES);
              shadow_hi_d = arith_hi;
              shadow_lo_d = arith_lo;
              shadow_dz_d = arith_dz;
            end
            MDU_MTHI: hi_d = in1;
            MDU_MTLO: lo_d = in1;
            default: ;  // unknown codes behave as NOP
          endcase
        end
      end
      MDU_RUN: begin
        // req is deliberately ignored here: the in-flight op is older than
        // the faulting instruction and must retire.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
          if (!shadow_dz_q) begin
            hi_d = shadow_hi_q;
            lo_d = shadow_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow registers are reset too, so a result discarded by
      // a mid-operation reset can never leak into HI/LO later.
      state_q     <= MDU_IDLE;
      cnt_q       <= '0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      shadow_hi_q <= 32'd0;
      shadow_lo_q <= 32'd0;
      shadow_dz_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register see the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      shadow_dz_q <= shadow_dz_d;
      busy_q      <= (state_d == MDU_RUN);
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Testbench: tb_mdu_sequencer
// Directed, self-checking bench for mdu_sequencer (MULT 5 / DIV 10 cycles).
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Architectural HI/LO the bench expects, maintained by hand per test.
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .in1    (in1),
    .in2    (in2),
    .req    (req),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Issue one op at the next edge, then count busy cycles (bounded).
  // req is raised for one cycle when the busy count equals req_at.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int req_at, output int n, output logic first_busy,
                        output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    start = 1'b1; mdu_op = op; in1 = a; in2 = b; req = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NOP;
    first_busy = busy; mid_hi = hi; mid_lo = lo;
    n = 0;
    while (busy && n < 40) begin
      req = (n == req_at);
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must win over a concurrent MTHI.
    reset = 1'b1; start = 1'b1; mdu_op = MDU_MTHI; in1 = 32'hDEADBEEF; in2 = 32'd0; req = 1'b0;
    repeat (2) @(posedge clk);
    #1; start = 1'b0; mdu_op = MDU_NOP; reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_mult();
    int n; logic fb; logic [31:0] mh, ml;
    run_op(MDU_MULT, 32'hFFFFFFFD, 32'd7, -1, n, fb, mh, ml);
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL mult_busy_rise got %b want 1", fb); end
    checks++; if (mh !== exp_hi || ml !== exp_lo) begin errors++;
      $display("FAIL mult_hold got %h_%h want %h_%h", mh, ml, exp_hi, exp_lo); end
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_latency got %0d want 5", n); end
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFEB;
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL mult_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end

    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, n, fb, mh, ml);
    exp_hi = 32'hFFFFFFFE; exp_lo = 32'h00000001;
    checks++; if (n !== 5 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL multu_result got n=%0d %h_%h want n=5 %h_%h", n, hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_div();
    int n; logic fb; logic [31:0] mh, ml;
    run_op(MDU_DIVU, 32'd100, 32'd7, -1, n, fb, mh, ml);
    checks++; if (n !== 10) begin errors++; $display("FAIL divu_latency got %0d want 10", n); end
    checks++; if (mh !== exp_hi || ml !== exp_lo) begin errors++;
      $display("FAIL divu_hold got %h_%h want %h_%h", mh, ml, exp_hi, exp_lo); end
    exp_hi = 32'd2; exp_lo = 32'd14;
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL divu_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end

    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, -1, n, fb, mh, ml);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
    checks++; if (n !== 10 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL div_signed got n=%0d %h_%h want n=10 %h_%h", n, hi, lo, exp_hi, exp_lo); end

    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, -1, n, fb, mh, ml);
    exp_hi = 32'd0; exp_lo = 32'h80000000;
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL div_overflow got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_move_and_dz();
    int n; logic fb; logic [31:0] mh, ml;
    run_op(MDU_MTHI, 32'h12345678, 32'd0, -1, n, fb, mh, ml);
    exp_hi = 32'h12345678;
    checks++; if (fb !== 1'b0 || n !== 0) begin errors++;
      $display("FAIL mthi_busy got busy=%b n=%0d want busy=0 n=0", fb, n); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL mthi_value got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end

    run_op(MDU_MTLO, 32'hCAFEF00D, 32'd0, -1, n, fb, mh, ml);
    exp_lo = 32'hCAFEF00D;
    checks++; if (fb !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL mtlo_value got busy=%b %h_%h want busy=0 %h_%h", fb, hi, lo, exp_hi, exp_lo); end

    run_op(MDU_DIV, 32'd55, 32'd0, -1, n, fb, mh, ml);
    checks++; if (n !== 10 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL div_zero got n=%0d %h_%h want n=10 %h_%h", n, hi, lo, exp_hi, exp_lo); end

    run_op(MDU_DIVU, 32'hFFFFFFFF, 32'd0, -1, n, fb, mh, ml);
    checks++; if (n !== 10 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL divu_zero got n=%0d %h_%h want n=10 %h_%h", n, hi, lo, exp_hi, exp_lo); end

    run_op(4'hF, 32'h11111111, 32'h22222222, -1, n, fb, mh, ml);
    checks++; if (fb !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL unknown_op got busy=%b %h_%h want busy=0 %h_%h", fb, hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_req();
    int n; logic fb; logic [31:0] mh, ml;
    // Flush on the issue cycle: nothing happens.
    start = 1'b1; req = 1'b1; mdu_op = MDU_MULT; in1 = 32'd6; in2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; mdu_op = MDU_NOP;
    checks++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL req_flush got busy=%b %h_%h want busy=0 %h_%h", busy, hi, lo, exp_hi, exp_lo); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_flush_late got busy=%b want 0", busy); end

    // Flush while running does not disturb the in-flight op.
    run_op(MDU_MULT, 32'd6, 32'd7, 2, n, fb, mh, ml);
    exp_hi = 32'd0; exp_lo = 32'd42;
    checks++; if (n !== 5 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL req_in_run got n=%0d %h_%h want n=5 %h_%h", n, hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_mid();
    int n; logic fb; logic [31:0] mh, ml;
    start = 1'b1; mdu_op = MDU_DIV; in1 = 32'd1000; in2 = 32'd3;
    @(posedge clk); #1;                 // RUN cycle 1
    start = 1'b0; mdu_op = MDU_NOP;
    repeat (2) @(posedge clk);          // RUN cycle 3
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    checks++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL reset_mid got busy=%b %h_%h want busy=0 0_0", busy, hi, lo); end
    // Ride out what would have been the rest of the DIV window.
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL reset_discard got busy=%b %h_%h want busy=0 0_0", busy, hi, lo); end
    run_op(MDU_MULTU, 32'd3, 32'd5, -1, n, fb, mh, ml);
    exp_lo = 32'd15;
    checks++; if (n !== 5 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL reset_then_multu got n=%0d %h_%h want n=5 %h_%h", n, hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_back_to_back();
    int n; logic fb; logic [31:0] mh, ml;
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, -1, n, fb, mh, ml);
    exp_hi = 32'd1; exp_lo = 32'hFFFFFFFE;
    checks++; if (n !== 5 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL b2b_first got n=%0d %h_%h want n=5 %h_%h", n, hi, lo, exp_hi, exp_lo); end
    // Issue in the first cycle busy is low.
    run_op(MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, n, fb, mh, ml);
    checks++; if (fb !== 1'b1 || mh !== 32'd1 || ml !== 32'hFFFFFFFE) begin errors++;
      $display("FAIL b2b_accept got busy=%b %h_%h want busy=1 00000001_fffffffe", fb, mh, ml); end
    exp_hi = 32'd0; exp_lo = 32'd1;
    checks++; if (n !== 5 || hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL b2b_second got n=%0d %h_%h want n=5 %h_%h", n, hi, lo, exp_hi, exp_lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move_and_dz();
    test_req();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
